alarm_beeper: RTL
=================

Name: alarm_beeper

Overview:
Downstream consumer of the alarm clock's per-alarm `alarm_o` vector. It turns "any alarm ringing" into an audible piezo drive. The drive is a square-wave tone gated by an on/off beep cadence, grouped into bursts separated by a pause. It also reports which alarm is being served, for status LEDs and display.

Parameters:
- ALARMS_CNT, 7, width of alarm request vector
- TONE_HALF_CYC, 12500, clk_i cycles per tone half-period (2 kHz at 50 MHz)
- ON_CYC, 10000000, clk_i cycles per beep (200 ms)
- OFF_CYC, 10000000, clk_i cycles of silence between beeps in a group
- BEEPS_PER_GROUP, 4, beeps per burst, must be >= 1
- PAUSE_CYC, 40000000, clk_i cycles of silence after a burst

Ports:
- clk_i  in  1  system clock (50 MHz domain)
- rst_i  in  1  reset
- alarm_i  in  ALARMS_CNT  per-alarm ringing levels; same clock domain, no synchroniser
- mute_i  in  1  level; silences buzzer without stopping cadence
- buzzer_o  out  1  registered piezo drive
- beep_active_o  out  1  registered; high while any alarm is being served
- active_idx_o  out  $clog2(ALARMS_CNT)  registered index of lowest-numbered asserted alarm

Interface rule: one clock; reset is synchronous and active-high (clk_i, rst_i).

Behaviour:
Reset:
- All outputs 0. State IDLE. All counters 0. Stored alarm vector 0.
- Reset asserted mid-beep forces this state on the next edge.

States: IDLE, BEEP_ON, BEEP_OFF, PAUSE.

Counters:
- phase_cnt (state duration), tone_cnt (tone half-period), beep_num (0..BEEPS_PER_GROUP-1).
- Each sized by $clog2 of its maximum.
- Terminal is max-1. No wrap beyond terminal.

Per edge:
- alarm_q <= alarm_i.
- new_req = |(alarm_i & ~alarm_q).

Transitions:
- IDLE -> BEEP_ON when |alarm_i. beep_num=0, counters cleared, tone phase=1.
- BEEP_ON lasts exactly ON_CYC cycles.
  - Then -> BEEP_OFF if beep_num < BEEPS_PER_GROUP-1.
  - Else -> PAUSE.
- BEEP_OFF lasts OFF_CYC cycles, then -> BEEP_ON with beep_num+1.
- PAUSE lasts PAUSE_CYC cycles, then -> BEEP_ON with beep_num=0.
- BEEPS_PER_GROUP=1: BEEP_ON -> PAUSE directly; BEEP_OFF is never entered.

Priority (highest first):
1. rst_i.
2. alarm_i==0: -> IDLE next edge from any state; all outputs 0 on that edge.
3. new_req while not IDLE: restart burst, i.e. -> BEEP_ON, beep_num=0, counters cleared, tone phase=1.
4. Normal cadence.

Tone:
- In BEEP_ON, tone phase toggles every TONE_HALF_CYC cycles. It starts at 1 on BEEP_ON entry.
- buzzer_o <= (next state==BEEP_ON) & next tone phase & ~mute_i.
- Consequently buzzer_o=1 on the same edge that enters BEEP_ON, unless muted.
- buzzer_o is 0 in every other state.

Mute:
- mute_i is sampled each edge with one-cycle effect.
- Tone counter and cadence keep running while muted.
- Unmuting mid-beep resumes at the current tone phase.

beep_active_o:
- Registered = (next state != IDLE).
- Rises on the same edge as IDLE -> BEEP_ON.

active_idx_o:
- Registered lowest set bit index of alarm_i, updated every edge while alarm_i != 0.
- Holds its last value when alarm_i==0.
- Reset value 0.
- Simultaneous bits: lowest index wins.

Test Plan:
(params: TONE_HALF_CYC=2, ON_CYC=8, OFF_CYC=4, BEEPS_PER_GROUP=2, PAUSE_CYC=12, ALARMS_CNT=7)
1. Cadence check.
   - Stimulus: alarm_i=7'b0000100 from cycle 0.
   - Response: beep_active_o=1 and buzzer_o pattern 1,1,0,0,1,1,0,0 (cycles 1-8); 4 cycles 0; second beep same 8-cycle pattern; 12 cycles 0; then repeats.
   - Response: active_idx_o=2 throughout.
2. Drop and reset recovery.
   - Stimulus: alarm_i drops to 0 mid-beep (3rd cycle of BEEP_ON).
   - Response: next edge buzzer_o=0, beep_active_o=0, active_idx_o holds 2.
   - Stimulus: rst_i pulsed mid-PAUSE.
   - Response: all outputs 0; first beep restarts only after alarm_i re-sampled nonzero post-reset.
3. Mute check.
   - Stimulus: mute_i=1 for cycles 3-20 with alarm active.
   - Response: buzzer_o=0 from cycle 4 to cycle 21 inclusive; cadence position identical to the unmuted run (second beep still starts at cycle 13).
4. Restart on new request.
   - Stimulus: alarm 2 active; alarm 0 asserts during PAUSE.
   - Response: next edge enters BEEP_ON with beep_num=0, buzzer_o=1, active_idx_o=0.
   - Stimulus: alarm 2 deasserting while alarm 0 stays.
   - Response: no restart, cadence uninterrupted.
5. Simultaneous requests.
   - Stimulus: alarm_i=7'b1010000 in one cycle from IDLE.
   - Response: active_idx_o=4, single burst start.
   - Stimulus: rerun with BEEPS_PER_GROUP=1.
   - Response: BEEP_ON -> PAUSE with no OFF phase (8 tone cycles, 12 silent).

Source files
------------

// File: rtl/alarm_beeper.sv
// alarm_beeper
//   Drives a piezo buzzer while any alarm is ringing. It produces a square-wave
//   tone that is gated by an on/off beep cadence. Beeps are grouped into bursts,
//   and each burst is followed by a silent pause. The block also reports the
//   lowest-numbered ringing alarm.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   alarm_i        per-alarm ringing levels (same clock domain)
//   mute_i         silences the buzzer; the cadence keeps running
//   buzzer_o       registered piezo drive
//   beep_active_o  registered; high while any alarm is being served
//   active_idx_o   registered index of the lowest asserted alarm; holds its
//                  value while no alarm is asserted
module alarm_beeper #(
   parameter int unsigned ALARMS_CNT      = 7,
   parameter int unsigned TONE_HALF_CYC   = 12500,
   parameter int unsigned ON_CYC          = 10000000,
   parameter int unsigned OFF_CYC         = 10000000,
   parameter int unsigned BEEPS_PER_GROUP = 4,
   parameter int unsigned PAUSE_CYC       = 40000000
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [ALARMS_CNT-1:0]         alarm_i,
   input  logic                          mute_i,
   output logic                          buzzer_o,
   output logic                          beep_active_o,
   output logic [$clog2(ALARMS_CNT)-1:0] active_idx_o
);

   localparam int unsigned IDX_W  = $clog2(ALARMS_CNT);
   localparam int unsigned PH_MAX =
      (ON_CYC >= OFF_CYC && ON_CYC >= PAUSE_CYC) ? ON_CYC :
      (OFF_CYC >= PAUSE_CYC)                     ? OFF_CYC : PAUSE_CYC;
   localparam int unsigned PH_W = (PH_MAX > 1)          ? $clog2(PH_MAX)          : 1;
   localparam int unsigned TN_W = (TONE_HALF_CYC > 1)   ? $clog2(TONE_HALF_CYC)   : 1;
   localparam int unsigned BN_W = (BEEPS_PER_GROUP > 1) ? $clog2(BEEPS_PER_GROUP) : 1;

   localparam logic [PH_W-1:0] ON_LAST    = PH_W'(ON_CYC - 1);
   localparam logic [PH_W-1:0] OFF_LAST   = PH_W'(OFF_CYC - 1);
   localparam logic [PH_W-1:0] PAUSE_LAST = PH_W'(PAUSE_CYC - 1);
   localparam logic [TN_W-1:0] TN_LAST    = TN_W'(TONE_HALF_CYC - 1);
   localparam logic [BN_W-1:0] BN_LAST    = BN_W'(BEEPS_PER_GROUP - 1);

   typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF, PAUSE} state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [TN_W-1:0]   tone_cnt_q, tone_cnt_d;
   logic              tone_q, tone_d;
   logic [BN_W-1:0]   beep_q, beep_d;
   logic [ALARMS_CNT-1:0] alarm_q;
   logic              new_req;
   logic [IDX_W-1:0]  idx_d;
   logic              idx_found;

   // Only a rising alarm bit counts as a new request.
   assign new_req = |(alarm_i & ~alarm_q);

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      tone_cnt_d = tone_cnt_q;
      tone_d     = tone_q;
      beep_d     = beep_q;
      if (alarm_i == '0) begin
         state_d    = IDLE;
         phase_d    = '0;
         tone_cnt_d = '0;
         tone_d     = 1'b0;
         beep_d     = '0;
      end else if (state_q == IDLE || new_req) begin
         // Start a fresh burst. A new request restarts it from the first beep.
         state_d    = BEEP_ON;
         phase_d    = '0;
         tone_cnt_d = '0;
         tone_d     = 1'b1;
         beep_d     = '0;
      end else begin
         case (state_q)
            BEEP_ON: begin
               if (tone_cnt_q == TN_LAST) begin
                  tone_cnt_d = '0;
                  tone_d     = ~tone_q;
               end else begin
                  tone_cnt_d = tone_cnt_q + 1'b1;
               end
               if (phase_q == ON_LAST) begin
                  phase_d    = '0;
                  tone_cnt_d = '0;
                  tone_d     = 1'b0;
                  state_d    = (beep_q == BN_LAST) ? PAUSE : BEEP_OFF;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
            BEEP_OFF: begin
               if (phase_q == OFF_LAST) begin
                  state_d    = BEEP_ON;
                  phase_d    = '0;
                  tone_cnt_d = '0;
                  tone_d     = 1'b1;
                  beep_d     = beep_q + 1'b1;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
            PAUSE: begin
               if (phase_q == PAUSE_LAST) begin
                  state_d    = BEEP_ON;
                  phase_d    = '0;
                  tone_cnt_d = '0;
                  tone_d     = 1'b1;
                  beep_d     = '0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Lowest set bit wins; the index holds while no alarm is asserted.
   always_comb begin
      idx_d     = active_idx_o;
      idx_found = 1'b0;
      for (int unsigned i = 0; i < ALARMS_CNT; i++) begin
         if (alarm_i[i] && !idx_found) begin
            idx_d     = IDX_W'(i);
            idx_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         phase_q       <= '0;
         tone_cnt_q    <= '0;
         tone_q        <= 1'b0;
         beep_q        <= '0;
         alarm_q       <= '0;
         buzzer_o      <= 1'b0;
         beep_active_o <= 1'b0;
         active_idx_o  <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         tone_cnt_q    <= tone_cnt_d;
         tone_q        <= tone_d;
         beep_q        <= beep_d;
         alarm_q       <= alarm_i;
         // Outputs are built from next-state values, so they line up with the state they describe.
         buzzer_o      <= (state_d == BEEP_ON) & tone_d & ~mute_i;
         beep_active_o <= (state_d != IDLE);
         active_idx_o  <= idx_d;
      end
   end

endmodule
